// File: rtl/key_event_decoder.sv
// key_event_decoder
// Turns four debounced key levels into discrete key events (press, release,
// long-press, auto-repeat), queues them in a small FIFO and presents the
// FIFO head over a valid/ready handshake.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        synchronous active-high reset
//   keys       debounced key levels, bit i = key i
//   evt_valid  FIFO head holds an event
//   evt_ready  consumer accepts the head this cycle
//   evt_key    key index of the head event (0 while evt_valid is low)
//   evt_type   00 press, 01 release, 10 long, 11 repeat (0 while evt_valid is low)
//   overflow   sticky flag, an event was dropped at a per-key pending slot
//   ovf_clr    clears overflow (a simultaneous drop wins)
module key_event_decoder #(
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter logic        PRESS_LEVEL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keys,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_key,
  output logic [1:0] evt_type,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int unsigned MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [PTR_W:0]   FIFO_FULL   = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESSED = 2'd1;
  localparam logic [1:0] ST_HELD    = 2'd2;

  localparam logic [1:0] EV_PRESS   = 2'b00;
  localparam logic [1:0] EV_RELEASE = 2'b01;
  localparam logic [1:0] EV_LONG    = 2'b10;
  localparam logic [1:0] EV_REPEAT  = 2'b11;

  logic [3:0]       k_q;
  logic [1:0]       state_q    [4];
  logic [1:0]       state_d    [4];
  logic [CNT_W-1:0] cnt_q      [4];
  logic [CNT_W-1:0] cnt_d      [4];
  logic [3:0]       pend_vld_q;
  logic [3:0]       pend_vld_d;
  logic [1:0]       pend_type_q[4];
  logic [1:0]       pend_type_d[4];
  logic             ovf_q;
  logic             ovf_d;

  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W:0]   count_q;

  logic [3:0] key_pressed;
  logic [3:0] gen_evt;
  logic [1:0] gen_type [4];
  logic [3:0] grant;
  logic [3:0] drop;
  logic       push;
  logic       pop;
  logic       can_push;
  logic [1:0] push_key;
  logic [1:0] push_type;

  assign key_pressed = PRESS_LEVEL ? k_q : ~k_q;

  // Per-key press/long/repeat state machines and event generation
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      gen_evt[i]  = 1'b0;
      gen_type[i] = EV_PRESS;
      case (state_q[i])
        ST_IDLE: begin
          if (key_pressed[i]) begin
            gen_evt[i]  = 1'b1;
            gen_type[i] = EV_PRESS;
            cnt_d[i]    = {CNT_W{1'b0}};
            state_d[i]  = ST_PRESSED;
          end else begin
            cnt_d[i] = {CNT_W{1'b0}};
          end
        end
        ST_PRESSED, ST_HELD: begin
          // Release outranks a long/repeat falling due in the same cycle
          if (!key_pressed[i]) begin
            gen_evt[i]  = 1'b1;
            gen_type[i] = EV_RELEASE;
            cnt_d[i]    = {CNT_W{1'b0}};
            state_d[i]  = ST_IDLE;
          end else if ((state_q[i] == ST_PRESSED) && (cnt_q[i] == LONG_LAST)) begin
            gen_evt[i]  = 1'b1;
            gen_type[i] = EV_LONG;
            cnt_d[i]    = {CNT_W{1'b0}};
            state_d[i]  = ST_HELD;
          end else if ((state_q[i] == ST_HELD) && (cnt_q[i] == REPEAT_LAST)) begin
            gen_evt[i]  = 1'b1;
            gen_type[i] = EV_REPEAT;
            cnt_d[i]    = {CNT_W{1'b0}};
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Fixed-priority arbiter (key 0 first) moving one pending event into the FIFO
  always_comb begin : arb
    logic found;
    found     = 1'b0;
    pop       = evt_valid & evt_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    can_push  = (count_q != FIFO_FULL) | pop;
    grant     = 4'b0000;
    push_key  = 2'd0;
    push_type = EV_PRESS;
    for (int i = 0; i < 4; i++) begin
      if (pend_vld_q[i] && can_push && !found) begin
        grant[i]  = 1'b1;
        found     = 1'b1;
        push_key  = 2'(i);
        push_type = pend_type_q[i];
      end else begin
        grant[i] = 1'b0;
      end
    end
    push = found;
  end

  // Pending slots: a slot being written out this cycle can take a new event
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pend_vld_d[i]  = pend_vld_q[i] & ~grant[i];
      pend_type_d[i] = pend_type_q[i];
      drop[i]        = 1'b0;
      if (gen_evt[i]) begin
        if (pend_vld_d[i]) begin
          drop[i] = 1'b1;
        end else begin
          pend_vld_d[i]  = 1'b1;
          pend_type_d[i] = gen_type[i];
        end
      end else begin
        drop[i] = 1'b0;
      end
    end
    if (|drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Input register, key FSM state, counters, pending slots and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q        <= {4{~PRESS_LEVEL}};
      pend_vld_q <= 4'b0000;
      ovf_q      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        state_q[i]     <= ST_IDLE;
        cnt_q[i]       <= {CNT_W{1'b0}};
        pend_type_q[i] <= EV_PRESS;
      end
    end else begin
      k_q        <= keys;
      pend_vld_q <= pend_vld_d;
      ovf_q      <= ovf_d;
      for (int i = 0; i < 4; i++) begin
        state_q[i]     <= state_d[i];
        cnt_q[i]       <= cnt_d[i];
        pend_type_q[i] <= pend_type_d[i];
      end
    end
  end

  // Event FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= {PTR_W{1'b0}};
      rd_q    <= {PTR_W{1'b0}};
      count_q <= {(PTR_W + 1){1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 4'b0000;
      end
    end else begin
      if (push) begin
        mem_q[wr_q] <= {push_key, push_type};
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign evt_valid = (count_q != {(PTR_W + 1){1'b0}});
  assign evt_key   = evt_valid ? mem_q[rd_q][3:2] : 2'd0;
  assign evt_type  = evt_valid ? mem_q[rd_q][1:0] : 2'd0;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Testbench for key_event_decoder. A behavioural model tracks, per key, how
// long it has been held since its press event and derives long/repeat events
// from that age; a one-deep pending slot per key, a fixed-priority drain and
// a queue stand in for the event path. Every cycle the DUT outputs are
// compared with the model, and directed scenarios add literal expectations.
module tb_key_event_decoder;

  localparam int LONG  = 20;
  localparam int REP   = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] keys = 4'hF;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_key;
  logic [1:0] evt_type;
  logic       overflow;

  key_event_decoder #(
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(REP),
    .FIFO_DEPTH   (DEPTH),
    .PRESS_LEVEL  (1'b0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .keys     (keys),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_key  (evt_key),
    .evt_type (evt_type),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // model state
  logic [3:0] m_k = 4'hF;
  bit   [3:0] m_act = 4'b0;
  int         m_age [4];
  bit   [3:0] m_pv = 4'b0;
  logic [1:0] m_pt [4];
  logic [3:0] m_q [$];
  bit         m_ovf = 1'b0;

  // events accepted by the consumer, as seen on the DUT handshake
  logic [3:0] log_ev [$];
  int         log_cyc [$];

  int         exp_dt [6] = '{0, 20, 28, 36, 44, 47};
  logic [1:0] exp_ty [6] = '{2'd0, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1};

  task automatic model_step();
    bit         pop;
    bit         can_push;
    int         g;
    bit   [3:0] gen;
    logic [1:0] gt [4];
    bit         drop;
    cyc++;
    if (rst) begin
      m_k   = 4'hF;
      m_act = 4'b0;
      m_pv  = 4'b0;
      m_ovf = 1'b0;
      m_q.delete();
      for (int i = 0; i < 4; i++) m_age[i] = 0;
      return;
    end
    pop      = (m_q.size() != 0) && evt_ready;
    can_push = (m_q.size() < DEPTH) || pop;
    g = -1;
    for (int i = 0; i < 4; i++) if (m_pv[i] && can_push && g < 0) g = i;
    for (int i = 0; i < 4; i++) begin
      gen[i] = 1'b0;
      gt[i]  = 2'd0;
      if (!m_act[i]) begin
        if (m_k[i] == 1'b0) begin
          gen[i] = 1'b1; gt[i] = 2'd0; m_act[i] = 1'b1; m_age[i] = 0;
        end
      end else if (m_k[i] == 1'b1) begin
        gen[i] = 1'b1; gt[i] = 2'd1; m_act[i] = 1'b0;
      end else begin
        m_age[i]++;
        if (m_age[i] == LONG) begin
          gen[i] = 1'b1; gt[i] = 2'd2;
        end else if (m_age[i] > LONG && ((m_age[i] - LONG) % REP) == 0) begin
          gen[i] = 1'b1; gt[i] = 2'd3;
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back({2'(g), m_pt[g]});
      m_pv[g] = 1'b0;
    end
    drop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (gen[i]) begin
        if (m_pv[i]) drop = 1'b1;
        else begin m_pv[i] = 1'b1; m_pt[i] = gt[i]; end
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    m_k = keys;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // per-cycle comparison against the model, plus handshake logging
  initial begin : cmp
    logic [5:0] exp_v;
    logic [5:0] got_v;
    forever begin
      @(negedge clk);
      exp_v = (m_q.size() != 0) ? {1'b1, m_q[0], m_ovf} : {1'b0, 4'b0000, m_ovf};
      got_v = {evt_valid, evt_key, evt_type, overflow};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle_out @%0d: got valid/key/type/ovf=%b required %b", cyc, got_v, exp_v);
      end
      if (evt_valid && evt_ready) begin
        log_ev.push_back({evt_key, evt_type});
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [3:0] head_or_f();
    return (m_q.size() > 0) ? m_q[0] : 4'hF;
  endfunction

  function automatic logic [3:0] log_at(input int idx);
    return (idx < log_ev.size()) ? log_ev[idx] : 4'hF;
  endfunction

  function automatic int dcyc(input int idx);
    return (idx < log_cyc.size() && log_cyc.size() > 0) ? log_cyc[idx] - log_cyc[0] : -1;
  endfunction

  initial begin
    // reset
    tick(3);
    chk("rst_outputs", 32'({evt_valid, evt_key, evt_type, overflow}), 32'h0);
    rst = 1'b0;
    tick(50);
    chk("idle_no_event", 32'({evt_valid, overflow}), 32'h0);

    // single tap on key 1
    evt_ready = 1'b1;
    keys = 4'hD;
    tick(2);
    chk("tap_not_yet", 32'(evt_valid), 32'h0);
    tick(1);
    chk("tap_press", 32'({evt_valid, evt_key, evt_type}), 32'({1'b1, 2'd1, 2'b00}));
    chk("model_tap_size", 32'(m_q.size()), 32'd1);
    chk("model_tap_head", 32'(head_or_f()), 32'h4);
    tick(2);
    keys = 4'hF;
    tick(2);
    chk("rel_not_yet", 32'(evt_valid), 32'h0);
    tick(1);
    chk("tap_release", 32'({evt_valid, evt_key, evt_type}), 32'({1'b1, 2'd1, 2'b01}));
    tick(10);

    // long press and repeats on key 2
    log_ev.delete(); log_cyc.delete();
    keys = 4'hB;
    tick(2);
    tick(45);
    keys = 4'hF;
    tick(10);
    chk("long_count", 32'(log_ev.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("long_ev%0d", i), 32'(log_at(i)), 32'({2'd2, exp_ty[i]}));
      chk($sformatf("long_dt%0d", i), 32'(dcyc(i)), 32'(exp_dt[i]));
    end

    // keys 0 and 3 together
    log_ev.delete(); log_cyc.delete();
    keys = 4'h6;
    tick(6);
    keys = 4'hF;
    tick(8);
    chk("simul_count", 32'(log_ev.size()), 32'd4);
    chk("simul_first", 32'(log_at(0)), 32'h0);
    chk("simul_second", 32'(log_at(1)), 32'hC);
    chk("simul_gap", 32'(dcyc(1)), 32'd1);
    chk("simul_ovf", 32'(overflow), 32'h0);

    // backpressure, pending fill and overflow
    log_ev.delete(); log_cyc.delete();
    evt_ready = 1'b0;
    keys = 4'h0;
    tick(8);
    keys = 4'hF;
    tick(3);
    keys = 4'h0;
    tick(3);
    chk("bp_overflow_set", 32'(overflow), 32'h1);
    chk("bp_valid", 32'(evt_valid), 32'h1);
    chk("model_bp_size", 32'(m_q.size()), 32'd4);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("bp_overflow_clr", 32'(overflow), 32'h0);
    evt_ready = 1'b1;
    keys = 4'hF;
    tick(30);
    chk("drain_count", 32'(log_ev.size()), 32'd10);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain_press%0d", i), 32'(log_at(i)), 32'({2'(i), 2'b00}));
    end
    chk("drain_rel0", 32'(log_at(4)), 32'h1);
    chk("drain_rel1", 32'(log_at(5)), 32'h5);
    chk("drain_empty", 32'(evt_valid), 32'h0);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    tick(5);

    // reset while key 1 is in the held phase
    keys = 4'hD;
    tick(26);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_outputs", 32'({evt_valid, evt_key, evt_type, overflow}), 32'h0);
    tick(2);
    chk("midrst_not_yet", 32'(evt_valid), 32'h0);
    tick(1);
    chk("midrst_press", 32'({evt_valid, evt_key, evt_type}), 32'({1'b1, 2'd1, 2'b00}));
    keys = 4'hF;
    tick(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
